always_combi: RTL and testbench
===============================

Name: always_combi

Overview:
- Bitwise-AND reference block that produces the same function two ways: a continuous-assignment path and a procedural combinational path.
- Adds a registered copy, an equivalence checker between the two combinational paths, and a saturating "AND-true" cycle counter.
- Used as a small self-checking primitive and as an example of coding-style equivalence in the datapath library.

Parameters:
- WIDTH, 1, bit width of operands a, b and of all AND outputs.
- CNT_W, 8, width of the AND-true cycle counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_assign  output  WIDTH  a & b, produced by continuous assignment.
- out_alwaysblock  output  WIDTH  a & b, produced by a combinational procedural block.
- out_reg  output  WIDTH  registered a & b.
- mismatch  output  1  sticky flag: the two combinational outputs differed at a clock edge.
- and_cnt  output  CNT_W  saturating count of clock edges where a & b is non-zero.

Behaviour:
- out_assign = a & b, bitwise, purely combinational, zero latency. Not affected by rst or clk.
- out_alwaysblock = a & b, bitwise, combinational procedural block with full sensitivity.
  - Blocking assignment; no latch; zero latency.
  - Must equal out_assign at all times after delta settling.
  - Not affected by rst or clk.
- out_reg:
  - Captures a & b on each rising clk edge, so it follows the combinational outputs with 1-cycle latency.
  - Reset value is all zeros, applied asynchronously on rst assertion.
- mismatch:
  - Set to 1 on a rising edge when out_assign != out_alwaysblock.
  - Stays 1 until rst.
  - Reset value 0.
- and_cnt:
  - Increments by 1 on each rising edge where |(a & b) == 1.
  - Saturates at 2^CNT_W − 1: no wrap-around, and it holds at max.
  - Reset value 0.
- Reset:
  - rst asserted at any time forces out_reg, mismatch and and_cnt to 0 immediately, independent of clk.
  - While rst is high, registers hold 0 and edges are ignored.
  - On the first rising edge after rst deasserts, normal capture and counting resume.
- Reset mid-operation: a count in progress is discarded, with no partial state kept.
- Inputs X/Z: no requirement beyond standard 4-state AND propagation. mismatch only reacts to known-value differences (use the !== comparison on the outputs, then gate by known-ness).
- All registered logic is in a single clocked block with async reset. Combinational paths contain no state.

Decomposition:
- Shared package: default WIDTH and CNT_W constants, and a saturating-increment function (CNT_W-generic via parameterized-width usage).
- One natural sub-module: sat_counter (enable, async reset, saturate at max), instantiated for and_cnt.
- The AND paths, out_reg and the mismatch flag stay in the top module.

Test Plan:
- Apply rst=1, then release; a=0, b=1 held → out_assign=0, out_alwaysblock=0, out_reg=0 after edge, and_cnt=0, mismatch=0.
- At t=5 switch to a=1, b=0 → both combinational outputs stay 0 immediately; and_cnt unchanged; mismatch=0.
- a=1, b=1 → out_assign=1 and out_alwaysblock=1 in the same delta-settled time step; out_reg=1 exactly one rising edge later; and_cnt increments by 1 per edge.
- CNT_W=2: hold a=b=1 for 6 edges → and_cnt sequence 1, 2, 3, 3, 3, 3 (saturation, no wrap).
- Assert rst asynchronously between edges while and_cnt=3 and out_reg=1 → both go to 0 immediately without a clock edge; the combinational outputs remain 1 while a=b=1.
- WIDTH=4: a=4'b1100, b=4'b1010 → out_assign=out_alwaysblock=4'b1000, out_reg=4'b1000 after one edge, and_cnt increments; mismatch remains 0 throughout all scenarios.

Source files
------------

// File: rtl/always_combi_pkg.sv
// always_combi_pkg: shared constants and helpers for the always_combi block.
//   DEFAULT_WIDTH  - default operand / AND-output width
//   DEFAULT_CNT_W  - default width of the AND-true cycle counter
//   sat_inc()      - saturating increment, usable for any counter width <= 32
package always_combi_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 8;

  // Callers zero-extend their count to 32 bits and pass their own maximum.
  // The result is then truncated back to the caller's width, so one function
  // serves every counter width up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/always_combi_sat_counter.sv
// sat_counter: enable-gated up-counter that holds at its maximum value.
//   clk_i  - rising-edge clock
//   rst_i  - asynchronous active-high reset, clears the count
//   en_i   - count enable, sampled on each rising edge
//   cnt_o  - current count, saturates at 2**CNT_W - 1
module sat_counter
  import always_combi_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), MAX_VAL));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/always_combi.sv
// always_combi: bitwise-AND reference block. The same a & b is produced by a
// continuous assignment and by a combinational procedural block; a registered
// copy, a sticky equivalence checker and a saturating AND-true counter are
// added on top.
//   clk             - rising-edge clock
//   rst             - asynchronous active-high reset
//   a, b            - operands
//   out_assign      - a & b, continuous assignment
//   out_alwaysblock - a & b, procedural combinational block
//   out_reg         - a & b registered (1-cycle latency)
//   mismatch        - sticky: the two combinational outputs differed at an edge
//   and_cnt         - saturating count of edges where a & b is non-zero
module always_combi
  import always_combi_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out_assign,
  output logic [WIDTH-1:0] out_alwaysblock,
  output logic [WIDTH-1:0] out_reg,
  output logic             mismatch,
  output logic [CNT_W-1:0] and_cnt
);

  logic [WIDTH-1:0] out_reg_q, out_reg_d;
  logic             mismatch_q, mismatch_d;
  logic             paths_differ;
  logic             paths_known;

  assign out_assign = a & b;

  always_comb begin
    out_alwaysblock = a & b;
  end

  // Only a difference between fully known values counts; X/Z on the inputs
  // propagates through both paths and must not trip the sticky flag.
  assign paths_differ = (out_assign !== out_alwaysblock);
  assign paths_known  = ((^{out_assign, out_alwaysblock}) !== 1'bx);

  always_comb begin
    out_reg_d  = a & b;
    mismatch_d = mismatch_q | (paths_differ & paths_known);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      out_reg_q  <= out_reg_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign out_reg  = out_reg_q;
  assign mismatch = mismatch_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_and_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (|(a & b)),
    .cnt_o (and_cnt)
  );

endmodule

// File: tb/tb_always_combi.sv
module tb_always_combi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Narrow instance: WIDTH=1, CNT_W=2 (saturation at 3 is reachable quickly)
  logic       a1, b1;
  logic       oa1, ob1, or1, mm1;
  logic [1:0] cnt1;

  // Wide instance: WIDTH=4, default 8-bit counter
  logic [3:0] a4, b4;
  logic [3:0] oa4, ob4, or4;
  logic       mm4;
  logic [7:0] cnt4;

  always_combi #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .out_assign(oa1), .out_alwaysblock(ob1), .out_reg(or1),
    .mismatch(mm1), .and_cnt(cnt1)
  );

  always_combi #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .out_assign(oa4), .out_alwaysblock(ob4), .out_reg(or4),
    .mismatch(mm4), .and_cnt(cnt4)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  int unsigned exp_reg1, exp_cnt1;
  int unsigned exp_reg4, exp_cnt4;
  localparam int unsigned MAX1 = 3;
  localparam int unsigned MAX4 = 255;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned and_ref(input int unsigned x, input int unsigned y);
    return x & y;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".oa1"},  32'(oa1),  and_ref(32'(a1), 32'(b1)));
    check({ctx, ".ob1"},  32'(ob1),  and_ref(32'(a1), 32'(b1)));
    check({ctx, ".or1"},  32'(or1),  exp_reg1);
    check({ctx, ".cnt1"}, 32'(cnt1), exp_cnt1);
    check({ctx, ".mm1"},  32'(mm1),  32'd0);
    check({ctx, ".oa4"},  32'(oa4),  and_ref(32'(a4), 32'(b4)));
    check({ctx, ".ob4"},  32'(ob4),  and_ref(32'(a4), 32'(b4)));
    check({ctx, ".or4"},  32'(or4),  exp_reg4);
    check({ctx, ".cnt4"}, 32'(cnt4), exp_cnt4);
    check({ctx, ".mm4"},  32'(mm4),  32'd0);
  endtask

  task automatic model_reset();
    exp_reg1 = 0; exp_cnt1 = 0;
    exp_reg4 = 0; exp_cnt4 = 0;
  endtask

  // One rising edge: update the model from the held inputs, then check.
  task automatic tick(input string ctx);
    int unsigned p1, p4;
    @(posedge clk);
    if (!rst) begin
      p1 = and_ref(32'(a1), 32'(b1));
      p4 = and_ref(32'(a4), 32'(b4));
      exp_reg1 = p1;
      exp_reg4 = p4;
      if (p1 != 0 && exp_cnt1 < MAX1) exp_cnt1 = exp_cnt1 + 1;
      if (p4 != 0 && exp_cnt4 < MAX4) exp_cnt4 = exp_cnt4 + 1;
    end
    #1;
    check_all(ctx);
  endtask

  task automatic drive(input logic na1, input logic nb1, input logic [3:0] na4, input logic [3:0] nb4);
    @(negedge clk);
    a1 = na1; b1 = nb1; a4 = na4; b4 = nb4;
    #1;
    check_all("comb");
  endtask

  initial begin
    int unsigned seq [6];
    seq = '{1, 2, 3, 3, 3, 3};
    model_reset();

    // Reset state
    a1 = 1'b0; b1 = 1'b1; a4 = 4'h0; b4 = 4'h0;
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    tick("after_rst");

    // a=1, b=0: outputs stay 0, no counting
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    tick("a1b0");

    // a=b=1 for six edges: counter 1,2,3,3,3,3
    drive(1'b1, 1'b1, 4'h0, 4'h0);
    check("comb_and_one", 32'(oa1), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick("sat");
      check("cnt_seq", 32'(cnt1), 32'(seq[i]));
    end
    check("reg_follows", 32'(or1), 32'd1);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_cnt_zero", 32'(cnt1), 32'd0);
    check("comb_held_in_rst", 32'(ob1), 32'd1);
    tick("in_rst");
    @(negedge clk);
    rst = 1'b0;
    tick("rst_release");

    // Wide operands
    drive(1'b0, 1'b0, 4'b1100, 4'b1010);
    check("wide_comb", 32'(ob4), 32'h8);
    tick("wide");
    check("wide_reg", 32'(or4), 32'h8);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom | ($urandom & 32'hF));
      if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rand_rst");
        rst = 1'b0;
      end else begin
        #1;
        check_all("rand_comb");
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net: the stimulus is clock-paced, so this never fires normally.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
